// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: debounces the board buttons, enforces the A -> B -> op load order and latches the ALU result onto the LEDs
module alu_seq_ctrl #(
    parameter int N_BITS     = 8,
    parameter int N_OP       = 6,
    parameter int N_DEBOUNCE = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [N_BITS-1:0] i_switch,
    input  logic [2:0]        i_boton,
    input  logic [N_BITS-1:0] i_result,
    output logic [N_BITS-1:0] o_dato_a,
    output logic [N_BITS-1:0] o_dato_b,
    output logic [N_OP-1:0]   o_op,
    output logic [N_BITS-1:0] o_leds,
    output logic [1:0]        o_state,
    output logic              o_err
);
    localparam int CW = $clog2(N_DEBOUNCE);

    typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, WAIT_OP = 2'd2, RESULT = 2'd3} state_t;

    state_t          state;
    logic [2:0]      sync1, sync2, press;
    logic [N_OP-1:0] opc;
    logic            op_ok, multi, pa, pb, po;

    assign opc     = i_switch[N_OP-1:0];
    assign op_ok   = opc inside {N_OP'(6'b100000), N_OP'(6'b100010), N_OP'(6'b100100), N_OP'(6'b100101),
                                 N_OP'(6'b100110), N_OP'(6'b000011), N_OP'(6'b000010), N_OP'(6'b100111)};
    assign pa      = press[0];
    assign pb      = press[1];
    assign po      = press[2];
    assign multi   = (pa & pb) | (pa & po) | (pb & po);
    assign o_state = state;

    // two-flop synchronizer bringing the raw buttons into the clock domain
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_boton;
            sync2 <= sync1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_deb
            logic [CW-1:0] cnt;
            logic          level, pulse;
            assign press[g] = pulse;
            // accept a new level only after it persists N_DEBOUNCE cycles; pulse once when a press is accepted
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt   <= '0;
                    level <= 1'b0;
                    pulse <= 1'b0;
                end else begin
                    pulse <= 1'b0;
                    if (sync2[g] == level) begin
                        cnt <= '0;
                    end else if (cnt == CW'(N_DEBOUNCE - 1)) begin
                        cnt   <= '0;
                        level <= sync2[g];
                        pulse <= sync2[g];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // load sequencer: every accepted A load restarts the B/op sequence, illegal pulses only raise the sticky error
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= WAIT_A;
            o_dato_a <= '0;
            o_dato_b <= '0;
            o_op     <= '0;
            o_err    <= 1'b0;
        end else if (multi) begin
            o_err <= 1'b1;
        end else if (pa) begin
            o_dato_a <= i_switch;
            o_err    <= 1'b0;
            state    <= WAIT_B;
        end else if (pb) begin
            if (state == WAIT_A) begin
                o_err <= 1'b1;
            end else begin
                o_dato_b <= i_switch;
                o_err    <= 1'b0;
                if (state == WAIT_B) state <= WAIT_OP;
            end
        end else if (po) begin
            if (state == WAIT_A || state == WAIT_B || !op_ok) begin
                o_err <= 1'b1;
            end else begin
                o_op  <= opc;
                o_err <= 1'b0;
                state <= RESULT;
            end
        end
    end

    // LEDs track the ALU only while a full operand/op set is loaded, otherwise hold
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) o_leds <= '0;
        else if (state == RESULT) o_leds <= i_result;
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: vector table, corner-case sequences and randomized presses against a load-order model
module tb_alu_seq_ctrl;
    localparam int NB = 8;
    localparam int NO = 6;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] i_switch = '0;
    logic [2:0]    i_boton = '0;
    logic [NB-1:0] i_result;
    logic [NB-1:0] o_dato_a, o_dato_b, o_leds;
    logic [NO-1:0] o_op;
    logic [1:0]    o_state;
    logic          o_err;

    int checks = 0;
    int failures = 0;

    alu_seq_ctrl #(.N_BITS(NB), .N_OP(NO), .N_DEBOUNCE(ND)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_switch(i_switch), .i_boton(i_boton),
        .i_result(i_result), .o_dato_a(o_dato_a), .o_dato_b(o_dato_b), .o_op(o_op),
        .o_leds(o_leds), .o_state(o_state), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h03: return $unsigned($signed(a) >>> b);
            6'h02: return a >> b;
            6'h27: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb i_result = alu_f(o_dato_a, o_dato_b, o_op);

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    typedef struct {
        logic [2:0] btn;
        logic [7:0] sw;
        logic [1:0] st;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] leds;
        logic       err;
    } vec_t;
    vec_t vecs [7];

    // model: which items are currently loaded, plus the values
    logic       ha, hb, hop, merr;
    logic [7:0] ma, mb, mleds;
    logic [5:0] mop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input logic [7:0] leds, input logic err);
        chk({tag, ".state"}, 32'(o_state), 32'(st));
        chk({tag, ".a"}, 32'(o_dato_a), 32'(a));
        chk({tag, ".b"}, 32'(o_dato_b), 32'(b));
        chk({tag, ".op"}, 32'(o_op), 32'(op));
        chk({tag, ".leds"}, 32'(o_leds), 32'(leds));
        chk({tag, ".err"}, 32'(o_err), 32'(err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_boton = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input logic [7:0] sw, input int hold);
        @(negedge clk);
        i_switch = sw;
        i_boton = m;
        repeat (hold) @(negedge clk);
        i_boton = '0;
        repeat (ND + 6) @(negedge clk);
    endtask

    function automatic logic is_valid(input logic [5:0] op);
        foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_press(input logic [2:0] m, input logic [7:0] sw);
        if ($countones(m) > 1) begin
            merr = 1'b1;
        end else if (m == 3'b001) begin
            ma = sw; merr = 1'b0; ha = 1'b1; hb = 1'b0; hop = 1'b0;
        end else if (m == 3'b010) begin
            if (!ha) merr = 1'b1;
            else begin mb = sw; hb = 1'b1; merr = 1'b0; end
        end else if (m == 3'b100) begin
            if (!(ha && hb) || !is_valid(sw[5:0])) merr = 1'b1;
            else begin mop = sw[5:0]; hop = 1'b1; merr = 1'b0; end
        end
        if (ha && hb && hop) mleds = alu_f(ma, mb, mop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'b001, 8'h5A, 2'd1, 8'h5A, 8'h00, 6'h00, 8'h00, 1'b0};
        vecs[1] = '{3'b010, 8'h0F, 2'd2, 8'h5A, 8'h0F, 6'h00, 8'h00, 1'b0};
        vecs[2] = '{3'b100, 8'h20, 2'd3, 8'h5A, 8'h0F, 6'h20, 8'h69, 1'b0};
        vecs[3] = '{3'b100, 8'h22, 2'd3, 8'h5A, 8'h0F, 6'h22, 8'h4B, 1'b0};
        vecs[4] = '{3'b100, 8'h27, 2'd3, 8'h5A, 8'h0F, 6'h27, 8'hA0, 1'b0};
        vecs[5] = '{3'b100, 8'h3F, 2'd3, 8'h5A, 8'h0F, 6'h27, 8'hA0, 1'b1};
        vecs[6] = '{3'b100, 8'h24, 2'd3, 8'h5A, 8'h0F, 6'h24, 8'h0A, 1'b0};

        do_reset();
        chk_all("reset", 2'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0);

        foreach (vecs[i]) begin
            press(vecs[i].btn, vecs[i].sw, 10);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].leds, vecs[i].err);
        end

        do_reset();
        press(3'b010, 8'h33, 10);
        chk_all("b_in_wait_a", 2'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b1);

        @(negedge clk);
        i_switch = 8'h77;
        i_boton = 3'b001;
        repeat (2) @(negedge clk);
        i_boton = '0;
        repeat (12) @(negedge clk);
        chk_all("glitch", 2'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b1);

        @(negedge clk);
        i_switch = 8'h11;
        i_boton = 3'b001;
        repeat (12) @(negedge clk);
        i_switch = 8'h22;
        repeat (38) @(negedge clk);
        i_boton = '0;
        repeat (ND + 6) @(negedge clk);
        chk_all("hold50", 2'd1, 8'h11, 8'h00, 6'h00, 8'h00, 1'b0);

        press(3'b011, 8'h99, 10);
        chk_all("a_and_b", 2'd1, 8'h11, 8'h00, 6'h00, 8'h00, 1'b1);

        press(3'b010, 8'h44, 10);
        chk_all("pre_async", 2'd2, 8'h11, 8'h44, 6'h00, 8'h00, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 2'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_reset();
        ha = 0; hb = 0; hop = 0; merr = 0; ma = 0; mb = 0; mop = 0; mleds = 0;
        for (int n = 0; n < 60; n++) begin
            logic [2:0] m;
            logic [7:0] sw;
            int r;
            r = $urandom_range(0, 15);
            if (r < 13) m = 3'(1 << (r % 3));
            else if (r == 13) m = 3'b011;
            else if (r == 14) m = 3'b101;
            else m = 3'b110;
            sw = 8'($urandom);
            if (m == 3'b100 && $urandom_range(0, 9) < 7) sw[5:0] = valid_ops[$urandom_range(0, 7)];
            press(m, sw, $urandom_range(ND + 4, 20));
            model_press(m, sw);
            chk_all($sformatf("rnd%0d", n), {ha && hb, ha && !(hb && !hop) ? 1'b1 : 1'b0} == 2'b00 && !ha ? 2'd0 :
                    (!hb ? 2'd1 : (!hop ? 2'd2 : 2'd3)), ma, mb, mop, mleds, merr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller between the board inputs (switches, push-buttons) and the combinational 8-op ALU. It debounces the three buttons, enforces the load order A -> B -> op, and validates the opcode against the supported set. It drives registered operands and opcode to the ALU and registers the ALU result onto the LEDs. It sits inside top, replacing the direct button-to-register latching.

Parameters:
N_BITS, 8, operand/result/switch width
N_OP, 6, opcode width (low N_OP bits of i_switch)
N_DEBOUNCE, 4, cycles a synchronized button level must persist before acceptance (≥2)

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset_n  in  1  asynchronous reset, active-low
i_switch  in  N_BITS  data/opcode source
i_boton  in  3  raw buttons: [0] load A, [1] load B, [2] load op
i_result  in  N_BITS  ALU combinational result
o_dato_a  out  N_BITS  registered operand A to ALU
o_dato_b  out  N_BITS  registered operand B to ALU
o_op  out  N_OP  registered opcode to ALU
o_leds  out  N_BITS  registered result
o_state  out  2  FSM state: 0 WAIT_A, 1 WAIT_B, 2 WAIT_OP, 3 RESULT
o_err  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): o_dato_a=o_dato_b=0, o_op=0, o_leds=0, o_err=0, o_state=WAIT_A, all debounce counters and levels cleared. Reset mid-operation discards partial loads.
- Per button: 2-flop synchronizer -> debouncer. Debounced level changes only after the synchronized level differs from it for N_DEBOUNCE consecutive cycles; any return resets the counter. One-cycle press pulse on debounced 0->1 edge. A held button yields exactly one pulse; re-arm requires a debounced release.
- Pulse latency: first pulse cycle = N_DEBOUNCE+2 edges (±1) after raw rise. Raw glitch shorter than N_DEBOUNCE cycles: no pulse.
- Valid opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR.
- Multiple pulses in the same cycle: all ignored, o_err<=1, state unchanged.
- WAIT_A: pulse A -> o_dato_a<=i_switch, ->WAIT_B. Pulse B or op -> o_err<=1, stay.
- WAIT_B: pulse B -> o_dato_b<=i_switch, ->WAIT_OP. Pulse A -> reload A, stay. Pulse op -> o_err<=1, stay.
- WAIT_OP: pulse op with valid opcode -> o_op<=i_switch[N_OP-1:0], ->RESULT. Invalid opcode -> o_err<=1, o_op unchanged, stay. Pulse A -> reload A, ->WAIT_B. Pulse B -> reload B, stay.
- RESULT: pulse op valid -> reload o_op, stay; invalid -> o_err<=1, o_op unchanged, stay. Pulse B -> reload B, stay. Pulse A -> reload A, ->WAIT_B.
- o_err: sticky. Cleared on any accepted (legal) load; setting takes priority only when no legal load occurs the same cycle.
- o_leds: o_leds<=i_result every cycle while o_state==RESULT. Otherwise it holds its value. Value reflects new operands/op one cycle after they are latched.
- Shifts and arithmetic are computed entirely in the ALU. The controller never alters data, only its width-truncation of i_switch to N_OP for opcode.

Test Plan:
- Reset, then press A with switch=0x5A, B with 0x0F, op with 0x20 (ADD), each held 10 cycles -> o_dato_a=0x5A, o_dato_b=0x0F, o_state=3, o_leds=0x69 one cycle after RESULT entry.
- In RESULT, press op with 0x22 (SUB) -> o_leds=0x4B; then 0x27 (NOR) -> o_leds=0xA0; o_err stays 0.
- In RESULT, press op with 0x3F (invalid) -> o_err=1, o_op stays 0x27, o_leds stays 0xA0. Next press op with 0x24 (AND) -> o_err=0, o_leds=0x0A.
- After reset, press B with 0x33 in WAIT_A -> o_err=1, o_dato_b=0, o_state=0. Raw 2-cycle glitch on button A -> no load, state 0.
- Hold button A for 50 cycles -> exactly one load. A and B pressed together -> o_err=1, no load.
- Assert i_reset_n low asynchronously (mid-cycle) in WAIT_OP -> all outputs 0 and o_state=0 immediately, before the next clock edge.
